axi4lite_slave_regs: RTL and testbench

AXI4-Lite responder (slave) terminating the AXI4-Lite bus driven by the team's initiator. It holds a small bank of read/write registers and serves the AW, W, B, AR and R channels with independent write and read state machines. The register contents are also exported as a flat vector for the surrounding tile logic.

---
 rtl/axi4lite_pkg.sv | 20 ++
 rtl/axi4lite_slave_wr_fsm.sv | 129 ++++++++++++
 rtl/axi4lite_slave_regs.sv | 146 ++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and write/read FSM state encodings.
// Used by both the responder and the team's initiator.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_ADDR,
      WR_HAVE_DATA,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_e;

endpackage

// File: rtl/axi4lite_slave_wr_fsm.sv
// AW/W join and B response for the AXI4-Lite register responder.
// Build option AXIL_SLVERR_EN: out-of-range writes answer SLVERR instead of OKAY.
module axi4lite_slave_wr_fsm
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     s_awaddr,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   output logic                      we_o,
   output logic [ADDR_WIDTH-1:0]     waddr_o,
   output logic [DATA_WIDTH-1:0]     wdata_o,
   output logic [DATA_WIDTH/8-1:0]   wstrb_o
);

   wr_state_e                 state_q;
   logic                      awready_q, wready_q, bvalid_q;
   logic [1:0]                bresp_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [DATA_WIDTH/8-1:0]   strb_q;

   logic aw_hs, w_hs, fire, in_range;
   logic [1:0] resp_d;

   assign aw_hs = s_awvalid & awready_q;
   assign w_hs  = s_wvalid & wready_q;

   // The write lands on the edge of the second handshake, so the live bus
   // value is used for whichever half arrives last.
   assign waddr_o = (state_q == WR_HAVE_ADDR) ? addr_q : s_awaddr;
   assign wdata_o = (state_q == WR_HAVE_DATA) ? data_q : s_wdata;
   assign wstrb_o = (state_q == WR_HAVE_DATA) ? strb_q : s_wstrb;

   always_comb begin
      fire = 1'b0;
      case (state_q)
         WR_IDLE:      fire = aw_hs & w_hs;
         WR_HAVE_ADDR: fire = w_hs;
         WR_HAVE_DATA: fire = aw_hs;
         default:      fire = 1'b0;
      endcase
   end

   assign in_range = int'(waddr_o) < NUM_REGS;
   assign we_o     = fire & in_range;

`ifdef AXIL_SLVERR_EN
   assign resp_d = in_range ? RESP_OKAY : RESP_SLVERR;
`else
   assign resp_d = RESP_OKAY;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WR_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         case (state_q)
            WR_IDLE: begin
               if (aw_hs && w_hs) begin
                  state_q   <= WR_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= resp_d;
               end else if (aw_hs) begin
                  state_q   <= WR_HAVE_ADDR;
                  addr_q    <= s_awaddr;
                  awready_q <= 1'b0;
               end else if (w_hs) begin
                  state_q  <= WR_HAVE_DATA;
                  data_q   <= s_wdata;
                  strb_q   <= s_wstrb;
                  wready_q <= 1'b0;
               end
            end
            WR_HAVE_ADDR: begin
               if (w_hs) begin
                  state_q  <= WR_RESP;
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= resp_d;
               end
            end
            WR_HAVE_DATA: begin
               if (aw_hs) begin
                  state_q   <= WR_RESP;
                  awready_q <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= resp_d;
               end
            end
            default: begin
               if (s_bready) begin
                  state_q   <= WR_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register-bank responder: write FSM sub-module, read FSM and bank here.
// Build option AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4lite_slave_regs
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          s_awaddr,
   input  logic                           s_awvalid,
   output logic                           s_awready,
   input  logic [DATA_WIDTH-1:0]          s_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
   input  logic                           s_wvalid,
   output logic                           s_wready,
   output logic [1:0]                     s_bresp,
   output logic                           s_bvalid,
   input  logic                           s_bready,
   input  logic [ADDR_WIDTH-1:0]          s_araddr,
   input  logic                           s_arvalid,
   output logic                           s_arready,
   output logic [DATA_WIDTH-1:0]          s_rdata,
   output logic [1:0]                     s_rresp,
   output logic                           s_rvalid,
   input  logic                           s_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   logic                      we;
   logic [ADDR_WIDTH-1:0]     waddr;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;

   logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]       wr_pulse_q;

   rd_state_e                 rd_state_q;
   logic                      arready_q, rvalid_q;
   logic [DATA_WIDTH-1:0]     rdata_q;
   logic [1:0]                rresp_q;
   logic [DATA_WIDTH-1:0]     rd_val;
   logic                      rd_in_range;

   axi4lite_slave_wr_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_wr_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_awaddr  (s_awaddr),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .we_o      (we),
      .waddr_o   (waddr),
      .wdata_o   (wdata),
      .wstrb_o   (wstrb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_pulse_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_pulse_q[i] <= we && (waddr == ADDR_WIDTH'(i));
            if (we && (waddr == ADDR_WIDTH'(i))) begin
               for (int unsigned k = 0; k < DATA_WIDTH/8; k++) begin
                  if (wstrb[k]) regs_q[i][k*8 +: 8] <= wdata[k*8 +: 8];
               end
            end
         end
      end
   end

   // Unmatched (out-of-range) addresses fall through to zero.
   always_comb begin
      rd_val = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (s_araddr == ADDR_WIDTH'(i)) rd_val = regs_q[i];
      end
   end

   assign rd_in_range = int'(s_araddr) < NUM_REGS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (s_arvalid) begin
                  rd_state_q <= RD_RESP;
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rdata_q    <= rd_val;
`ifdef AXIL_SLVERR_EN
                  rresp_q    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
                  rresp_q    <= RESP_OKAY;
`endif
               end
            end
            default: begin
               if (s_rready) begin
                  rd_state_q <= RD_IDLE;
                  arready_q  <= 1'b1;
                  rvalid_q   <= 1'b0;
               end
            end
         endcase
      end
   end

`ifndef AXIL_SLVERR_EN
   logic unused_rd_in_range;
   assign unused_rd_in_range = rd_in_range;
`endif

   always_comb begin
      reg_q = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

   assign wr_pulse  = wr_pulse_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: a 4-register instance and a 3-register
// instance for out-of-range accesses (expected bresp/rresp follow AXIL_SLVERR_EN).
module tb_axi4lite_slave_regs;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] EXP_OOR = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   // 4-register instance
   logic [1:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [7:0]  wdata = '0;
   logic [0:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [7:0]  rdata;
   logic [31:0] regq;
   logic [3:0]  wpulse;

   axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
      .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
      .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
      .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
      .reg_q(regq), .wr_pulse(wpulse)
   );

   // 3-register instance
   logic [1:0]  b_awaddr = '0, b_araddr = '0;
   logic        b_awvalid = 0, b_wvalid = 0, b_bready = 0, b_arvalid = 0, b_rready = 0;
   logic [7:0]  b_wdata = '0;
   logic [0:0]  b_wstrb = '0;
   logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
   logic [1:0]  b_bresp, b_rresp;
   logic [7:0]  b_rdata;
   logic [23:0] b_regq;
   logic [2:0]  b_wpulse;

   axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(b_awaddr), .s_awvalid(b_awvalid), .s_awready(b_awready),
      .s_wdata(b_wdata), .s_wstrb(b_wstrb), .s_wvalid(b_wvalid), .s_wready(b_wready),
      .s_bresp(b_bresp), .s_bvalid(b_bvalid), .s_bready(b_bready),
      .s_araddr(b_araddr), .s_arvalid(b_arvalid), .s_arready(b_arready),
      .s_rdata(b_rdata), .s_rresp(b_rresp), .s_rvalid(b_rvalid), .s_rready(b_rready),
      .reg_q(b_regq), .wr_pulse(b_wpulse)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Aligned write with bready high; returns bresp.
   task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                           output logic [1:0] resp);
      bit seen = 0;
      resp = 2'bxx;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      step();
      awvalid = 0; wvalid = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bvalid) begin
            seen = 1;
            resp = bresp;
         end else step();
      end
      if (!seen) check("wr_timeout", 0, 1);
      step();
   endtask

   task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic [1:0] resp);
      bit seen = 0;
      d = 'x; resp = 'x;
      araddr = a; arvalid = 1; rready = 1;
      step();
      arvalid = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (rvalid) begin
            seen = 1;
            d = rdata;
            resp = rresp;
         end else step();
      end
      if (!seen) check("rd_timeout", 0, 1);
      step();
   endtask

   logic [7:0] rd;
   logic [1:0] rs;

   initial begin
      // Reset state
      #12;
      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_arready", arready, 1);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_regs", regq, 0);
      check("rst_pulse", wpulse, 0);
      @(posedge clk); #1 rst_n = 1;
      step();

      // Aligned write addr 2 <- 0x04
      awaddr = 2; wdata = 8'h04; wstrb = 1; awvalid = 1; wvalid = 1; bready = 1;
      step();
      awvalid = 0; wvalid = 0;
      check("al_bvalid", bvalid, 1);
      check("al_bresp", bresp, 2'b00);
      check("al_reg2", regq[23:16], 8'h04);
      check("al_pulse", wpulse, 4'b0100);
      check("al_awready", awready, 0);
      step();
      check("al_bdone", bvalid, 0);
      check("al_pulse_clr", wpulse, 0);
      check("al_ready_back", awready, 1);
      araddr = 2; arvalid = 1; rready = 0;
      step();
      arvalid = 0;
      check("al_rvalid", rvalid, 1);
      check("al_rdata", rdata, 8'h04);
      check("al_arready", arready, 0);
      rready = 1;
      step();
      check("al_rdone", rvalid, 0);

      // W first, AW three cycles later
      wdata = 8'hA5; wstrb = 1; wvalid = 1;
      step();
      wvalid = 0;
      for (int i = 0; i < 2; i++) begin
         check("wf_wready", wready, 0);
         check("wf_awready", awready, 1);
         check("wf_reg1_pending", regq[15:8], 8'h00);
         step();
      end
      awaddr = 1; awvalid = 1;
      step();
      awvalid = 0;
      check("wf_reg1", regq[15:8], 8'hA5);
      check("wf_pulse", wpulse, 4'b0010);
      check("wf_bvalid", bvalid, 1);
      step();
      do_read(1, rd, rs);
      check("wf_rd1", rd, 8'hA5);

      // AW first, then W
      awaddr = 0; awvalid = 1;
      step();
      awvalid = 0;
      check("af_awready", awready, 0);
      check("af_wready", wready, 1);
      step();
      step();
      wdata = 8'h3C; wstrb = 1; wvalid = 1;
      step();
      wvalid = 0;
      check("af_reg0", regq[7:0], 8'h3C);
      check("af_pulse", wpulse, 4'b0001);
      step();

      // Write backpressure
      bready = 0;
      awaddr = 0; wdata = 8'h5A; wstrb = 1; awvalid = 1; wvalid = 1;
      step();
      awvalid = 0; wvalid = 0;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", bvalid, 1);
         check("bp_awready", awready, 0);
         check("bp_wready", wready, 0);
         step();
      end
      bready = 1;
      step();
      check("bp_bdone", bvalid, 0);
      check("bp_reg0", regq[7:0], 8'h5A);

      // Read backpressure with a second request waiting
      araddr = 1; arvalid = 1; rready = 0;
      step();
      araddr = 0;
      for (int i = 0; i < 4; i++) begin
         check("rbp_rvalid", rvalid, 1);
         check("rbp_rdata", rdata, 8'hA5);
         check("rbp_arready", arready, 0);
         step();
      end
      rready = 1;
      step();
      check("rbp_rdone", rvalid, 0);
      check("rbp_arready_back", arready, 1);
      rready = 0;
      step();
      arvalid = 0;
      check("rbp_second", rdata, 8'h5A);
      check("rbp_second_v", rvalid, 1);
      rready = 1;
      step();

      // Zero strobe leaves the register alone
      do_write(3, 8'hFF, 1'b0, rs);
      check("st_reg3", regq[31:24], 8'h00);

      // Same-edge write and read of addr 3
      awaddr = 3; wdata = 8'h55; wstrb = 1; awvalid = 1; wvalid = 1; bready = 1;
      araddr = 3; arvalid = 1; rready = 0;
      step();
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("col_old", rdata, 8'h00);
      check("col_reg3", regq[31:24], 8'h55);
      rready = 1;
      step();
      do_read(3, rd, rs);
      check("col_new", rd, 8'h55);

      // Reset while a write response and a read response are pending
      bready = 0; rready = 0;
      awaddr = 1; wdata = 8'h99; wstrb = 1; awvalid = 1; wvalid = 1;
      araddr = 2; arvalid = 1;
      step();
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("mr_bvalid_pre", bvalid, 1);
      check("mr_rvalid_pre", rvalid, 1);
      #2 rst_n = 0;
      #1;
      check("mr_bvalid", bvalid, 0);
      check("mr_rvalid", rvalid, 0);
      check("mr_regs", regq, 0);
      check("mr_readies", {awready, wready, arready}, 3'b111);
      @(posedge clk); #1 rst_n = 1;
      bready = 1; rready = 1;
      step();
      check("mr_regs_after", regq, 0);

      // Out-of-range access on the 3-register instance
      b_awaddr = 2; b_wdata = 8'h12; b_wstrb = 1; b_awvalid = 1; b_wvalid = 1; b_bready = 1;
      step();
      b_awvalid = 0; b_wvalid = 0;
      check("oor_inrange_resp", b_bresp, 2'b00);
      step();
      b_awaddr = 3; b_wdata = 8'h77; b_wstrb = 1; b_awvalid = 1; b_wvalid = 1;
      step();
      b_awvalid = 0; b_wvalid = 0;
      check("oor_bvalid", b_bvalid, 1);
      check("oor_bresp", b_bresp, EXP_OOR);
      check("oor_regs", b_regq, 24'h120000);
      check("oor_pulse", b_wpulse, 3'b000);
      step();
      b_araddr = 3; b_arvalid = 1; b_rready = 1;
      step();
      b_arvalid = 0;
      check("oor_rvalid", b_rvalid, 1);
      check("oor_rdata", b_rdata, 8'h00);
      check("oor_rresp", b_rresp, EXP_OOR);
      step();
      b_araddr = 2; b_arvalid = 1;
      step();
      b_arvalid = 0;
      check("oor_rd2", b_rdata, 8'h12);
      check("oor_rd2_resp", b_rresp, 2'b00);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
